alu_arbiter: RTL and testbench

//  Shares one alu instance between two requesters (r0, r1) via valid/ready handshakes.

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared alu: grants one operation at a time,
// drives the alu with latched operands and hands the captured result back to the granted requester.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned OPW     = 3,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_in1,
  input  logic [WIDTH-1:0] r0_in2,
  input  logic [OPW-1:0]   r0_op,
  output logic             r0_rvalid,
  input  logic             r0_rready,
  output logic [WIDTH-1:0] r0_result,
  output logic [1:0]       r0_z,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_in1,
  input  logic [WIDTH-1:0] r1_in2,
  input  logic [OPW-1:0]   r1_op,
  output logic             r1_rvalid,
  input  logic             r1_rready,
  output logic [WIDTH-1:0] r1_result,
  output logic [1:0]       r1_z,

  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [1:0]       alu_z,

  output logic             busy
);

  localparam int unsigned CntW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic             last_grant_q;
  logic             grant_q;
  logic [WIDTH-1:0] lat_in1_q, lat_in2_q;
  logic [OPW-1:0]   lat_op_q;
  logic [WIDTH-1:0] alu_in1_q, alu_in2_q;
  logic [OPW-1:0]   alu_op_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] r0_result_q, r1_result_q;
  logic [1:0]       r0_z_q, r1_z_q;

  logic any_valid;
  logic winner;
  logic accept;
  logic cnt_done;
  logic resp_done;

  // Only one requester valid: it wins. Both valid: the one not served last time wins.
  always_comb begin
    any_valid = r0_valid | r1_valid;
    if (r0_valid && r1_valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = r1_valid;
    end
    accept    = (state_q == StIdle) && any_valid;
    cnt_done  = (state_q == StWait) && (cnt_q == CntW'(1));
    resp_done = (state_q == StResp) && (grant_q ? r1_rready : r0_rready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (cnt_done) state_d = StResp;
      StResp:  if (resp_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    r0_ready  = accept & ~winner;
    r1_ready  = accept & winner;
    r0_rvalid = (state_q == StResp) & ~grant_q;
    r1_rvalid = (state_q == StResp) & grant_q;
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      lat_in1_q    <= '0;
      lat_in2_q    <= '0;
      lat_op_q     <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_op_q     <= '0;
      cnt_q        <= '0;
      r0_result_q  <= '0;
      r0_z_q       <= '0;
      r1_result_q  <= '0;
      r1_z_q       <= '0;
    end else begin
      if (accept) begin
        grant_q      <= winner;
        last_grant_q <= winner;
        lat_in1_q    <= winner ? r1_in1 : r0_in1;
        lat_in2_q    <= winner ? r1_in2 : r0_in2;
        lat_op_q     <= winner ? r1_op  : r0_op;
      end
      // alu inputs only change here, so the alu sees nothing but the granted operands.
      if (state_q == StIssue) begin
        alu_in1_q <= lat_in1_q;
        alu_in2_q <= lat_in2_q;
        alu_op_q  <= lat_op_q;
        cnt_q     <= CntW'(ALU_LAT);
      end
      if (state_q == StWait) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (cnt_done) begin
        if (grant_q) begin
          r1_result_q <= alu_out;
          r1_z_q      <= alu_z;
        end else begin
          r0_result_q <= alu_out;
          r0_z_q      <= alu_z;
        end
      end
    end
  end

  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_op    = alu_op_q;
  assign r0_result = r0_result_q;
  assign r0_z      = r0_z_q;
  assign r1_result = r1_result_q;
  assign r1_z      = r1_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural alu (op0 add, op1 sub) sits behind a
// default-latency instance and an ALU_LAT=3 instance.
module tb_alu_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        r0_valid, r0_ready, r0_rvalid, r0_rready;
  logic [15:0] r0_in1, r0_in2, r0_result;
  logic [2:0]  r0_op;
  logic [1:0]  r0_z;
  logic        r1_valid, r1_ready, r1_rvalid, r1_rready;
  logic [15:0] r1_in1, r1_in2, r1_result;
  logic [2:0]  r1_op;
  logic [1:0]  r1_z;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_op;
  logic [1:0]  alu_z;
  logic        busy;

  logic        b_r0_valid, b_r0_ready, b_r0_rvalid, b_r0_rready;
  logic [15:0] b_r0_in1, b_r0_in2, b_r0_result;
  logic [2:0]  b_r0_op;
  logic [1:0]  b_r0_z;
  logic        b_r1_valid, b_r1_ready, b_r1_rvalid, b_r1_rready;
  logic [15:0] b_r1_in1, b_r1_in2, b_r1_result;
  logic [2:0]  b_r1_op;
  logic [1:0]  b_r1_z;
  logic [15:0] b_alu_in1, b_alu_in2, b_alu_out;
  logic [2:0]  b_alu_op;
  logic [1:0]  b_alu_z;
  logic        b_busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] qb[$];
  logic [17:0] exp_v;
  logic [17:0] got;

  always #10 clock = ~clock;

  // Reference alu: {z, result}, z = {sign, zero}.
  function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    logic [15:0] r;
    r = (op == 3'd1) ? (a - b) : (a + b);
    return {r[15], (r == 16'd0), r};
  endfunction

  always_comb {alu_z, alu_out} = alu_ref(alu_in1, alu_in2, alu_op);
  always_comb {b_alu_z, b_alu_out} = alu_ref(b_alu_in1, b_alu_in2, b_alu_op);

  alu_arbiter #(.WIDTH(16), .OPW(3), .ALU_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_in1(r0_in1), .r0_in2(r0_in2),
    .r0_op(r0_op), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_result(r0_result),
    .r0_z(r0_z),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_in1(r1_in1), .r1_in2(r1_in2),
    .r1_op(r1_op), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_result(r1_result),
    .r1_z(r1_z),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .alu_z(alu_z), .busy(busy)
  );

  alu_arbiter #(.WIDTH(16), .OPW(3), .ALU_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_in1(b_r0_in1), .r0_in2(b_r0_in2),
    .r0_op(b_r0_op), .r0_rvalid(b_r0_rvalid), .r0_rready(b_r0_rready),
    .r0_result(b_r0_result), .r0_z(b_r0_z),
    .r1_valid(b_r1_valid), .r1_ready(b_r1_ready), .r1_in1(b_r1_in1), .r1_in2(b_r1_in2),
    .r1_op(b_r1_op), .r1_rvalid(b_r1_rvalid), .r1_rready(b_r1_rready),
    .r1_result(b_r1_result), .r1_z(b_r1_z),
    .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_op(b_alu_op), .alu_out(b_alu_out),
    .alu_z(b_alu_z), .busy(b_busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until the chosen requester sees rvalid; n = cycles stepped (40 = gave up).
  task automatic wait_rv(input bit which, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(which ? r1_rvalid : r0_rvalid) && n < 40);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    {r0_valid, r0_rready, r0_in1, r0_in2, r0_op} = '0;
    {r1_valid, r1_rready, r1_in1, r1_in2, r1_op} = '0;
    {b_r0_valid, b_r0_rready, b_r0_in1, b_r0_in2, b_r0_op} = '0;
    {b_r1_valid, b_r1_rready, b_r1_in1, b_r1_in2, b_r1_op} = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    got = {r0_rvalid, r1_rvalid, r0_ready, r1_ready, busy, alu_op, r0_z, r1_z, 6'd0};
    n_cmp++;
    if (got !== 18'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %h want 0", got);
    end
    n_cmp++;
    if ({alu_in1, alu_in2, r0_result, r1_result} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {alu_in1, alu_in2, r0_result, r1_result});
    end
  endtask

  task automatic test_single();
    int n;
    r0_in1 = 16'd1; r0_in2 = 16'd2; r0_op = 3'd0; r0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL single_ready: got %b want 10", {r0_ready, r1_ready});
    end
    q0.push_back(alu_ref(16'd1, 16'd2, 3'd0));
    step();
    r0_valid = 1'b0;
    n_cmp++;
    if ({r0_ready, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL single_busy: got %b want 01", {r0_ready, busy});
    end
    wait_rv(1'b0, n);
    n_cmp++;
    if (n != 2) begin
      n_err++;
      $display("FAIL single_latency: got %0d want 3", n + 1);
    end
    exp_v = q0.pop_front();
    n_cmp++;
    if ({r0_z, r0_result} !== exp_v || exp_v[15:0] !== 16'd3) begin
      n_err++;
      $display("FAIL single_result: got %h want %h", {r0_z, r0_result}, exp_v);
    end
    r0_rready = 1'b1;
    step();
    r0_rready = 1'b0;
    n_cmp++;
    if ({r0_rvalid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL single_done: got %b want 00", {r0_rvalid, busy});
    end
  endtask

  task automatic test_contention();
    int n;
    bit bad;
    apply_reset();
    r0_in1 = 16'd20; r0_in2 = 16'd100; r0_op = 3'd0; r0_valid = 1'b1;
    r1_in1 = 16'd10; r1_in2 = 16'd3;   r1_op = 3'd1; r1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL contend_first: got %b want 10", {r0_ready, r1_ready});
    end
    q0.push_back(alu_ref(16'd20, 16'd100, 3'd0));
    step();
    r0_valid = 1'b0;
    bad = 1'b0;
    n = 0;
    while (!r0_rvalid && n < 40) begin
      if (alu_in1 === 16'd10 || r1_ready) bad = 1'b1;
      step();
      n++;
    end
    if (alu_in1 === 16'd10 || r1_ready) bad = 1'b1;
    exp_v = q0.pop_front();
    n_cmp++;
    if ({r0_rvalid, r0_z, r0_result} !== {1'b1, exp_v}) begin
      n_err++;
      $display("FAIL contend_r0_result: got %h want %h", {r0_rvalid, r0_z, r0_result},
               {1'b1, exp_v});
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL contend_leak: got r1 operand on alu, want none");
    end
    r0_rready = 1'b1;
    step();
    r0_rready = 1'b0;
    n_cmp++;
    if ({r0_ready, r1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL contend_second: got %b want 01", {r0_ready, r1_ready});
    end
    q1.push_back(alu_ref(16'd10, 16'd3, 3'd1));
    step();
    r1_valid = 1'b0;
    wait_rv(1'b1, n);
    exp_v = q1.pop_front();
    n_cmp++;
    if ({r1_rvalid, r1_z, r1_result} !== {1'b1, exp_v} || exp_v[15:0] !== 16'd7) begin
      n_err++;
      $display("FAIL contend_r1_result: got %h want %h", {r1_rvalid, r1_z, r1_result},
               {1'b1, exp_v});
    end
    r1_rready = 1'b1;
    step();
    r1_rready = 1'b0;
  endtask

  task automatic test_alternation();
    int n;
    bit g;
    apply_reset();
    r0_rready = 1'b1; r1_rready = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0_in1 = 16'(7 + i); r0_in2 = 16'd7; r0_op = 3'd1;
      r1_in1 = 16'(i * 100); r1_in2 = 16'd5; r1_op = 3'd0;
      #1;
      n = 0;
      while (!(r0_ready || r1_ready) && n < 10) begin
        step();
        n++;
      end
      g = r1_ready;
      n_cmp++;
      if ({r0_ready, r1_ready} !== ((i % 2) ? 2'b01 : 2'b10)) begin
        n_err++;
        $display("FAIL alt_grant%0d: got %b want %b", i, {r0_ready, r1_ready},
                 (i % 2) ? 2'b01 : 2'b10);
      end
      if (i % 2) q1.push_back(alu_ref(r1_in1, r1_in2, r1_op));
      else q0.push_back(alu_ref(r0_in1, r0_in2, r0_op));
      step();
      wait_rv(g, n);
      exp_v = (i % 2) ? q1.pop_front() : q0.pop_front();
      got = (i % 2) ? {r1_z, r1_result} : {r0_z, r0_result};
      n_cmp++;
      if (got !== exp_v || n >= 40) begin
        n_err++;
        $display("FAIL alt_result%0d: got %h want %h", i, got, exp_v);
      end
      step();
    end
    {r0_valid, r1_valid, r0_rready, r1_rready} = '0;
    step();
  endtask

  task automatic test_backpressure();
    int n;
    r1_in1 = 16'd50; r1_in2 = 16'd7; r1_op = 3'd0; r1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({r0_ready, r1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_accept: got %b want 01", {r0_ready, r1_ready});
    end
    q1.push_back(alu_ref(16'd50, 16'd7, 3'd0));
    step();
    r1_valid = 1'b0;
    r0_in1 = 16'd1; r0_in2 = 16'd1; r0_op = 3'd0; r0_valid = 1'b1;
    wait_rv(1'b1, n);
    exp_v = q1[0];
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({r1_rvalid, r0_ready, busy, r0_rvalid, r1_z, r1_result} !==
          {4'b1010, exp_v}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got %h want %h", k,
                 {r1_rvalid, r0_ready, busy, r0_rvalid, r1_z, r1_result}, {4'b1010, exp_v});
      end
      step();
    end
    void'(q1.pop_front());
    r1_rready = 1'b1;
    r0_valid = 1'b0;
    step();
    r1_rready = 1'b0;
    n_cmp++;
    if ({r1_rvalid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL bp_release: got %b want 00", {r1_rvalid, busy});
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    bit seen;
    r0_in1 = 16'd9; r0_in2 = 16'd9; r0_op = 3'd0; r0_valid = 1'b1;
    step();
    r0_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({r0_rvalid, r1_rvalid, busy, alu_op, r0_z, alu_in1, alu_in2, r0_result} !== 56'd0) begin
      n_err++;
      $display("FAIL midreset_clear: got %h want 0",
               {r0_rvalid, r1_rvalid, busy, alu_op, r0_z, alu_in1, alu_in2, r0_result});
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (r0_rvalid || r1_rvalid) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL midreset_rvalid: got rvalid after reset, want none");
    end
    r0_in1 = 16'd2; r0_in2 = 16'd8; r0_op = 3'd1; r0_valid = 1'b1;
    #1;
    q0.push_back(alu_ref(16'd2, 16'd8, 3'd1));
    step();
    r0_valid = 1'b0;
    wait_rv(1'b0, n);
    exp_v = q0.pop_front();
    n_cmp++;
    if ({r0_z, r0_result} !== exp_v || exp_v[15:0] !== 16'hFFFA || n != 2) begin
      n_err++;
      $display("FAIL midreset_next: got %h after %0d want %h after 2", {r0_z, r0_result}, n,
               exp_v);
    end
    r0_rready = 1'b1;
    step();
    r0_rready = 1'b0;
  endtask

  task automatic test_long_latency();
    int n;
    apply_reset();
    b_r0_in1 = 16'd5; b_r0_in2 = 16'd6; b_r0_op = 3'd0; b_r0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({b_r0_ready, b_r1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL lat3_accept: got %b want 10", {b_r0_ready, b_r1_ready});
    end
    qb.push_back(alu_ref(16'd5, 16'd6, 3'd0));
    step();
    b_r0_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!b_r0_rvalid && n < 40);
    n_cmp++;
    if (n != 4) begin
      n_err++;
      $display("FAIL lat3_latency: got %0d want 5", n + 1);
    end
    exp_v = qb.pop_front();
    n_cmp++;
    if ({b_r0_z, b_r0_result} !== exp_v || exp_v[15:0] !== 16'd11 || b_busy !== 1'b1 ||
        {b_r1_rvalid, b_r1_z, b_r1_result} !== 19'd0) begin
      n_err++;
      $display("FAIL lat3_result: got %h want %h", {b_r0_z, b_r0_result}, exp_v);
    end
    b_r0_rready = 1'b1;
    step();
    b_r0_rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_alternation();
    test_backpressure();
    test_reset_mid_op();
    test_long_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
